uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter: state encoding,
// transmitter-start timeout length and the client index width.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE      = ST_IDLE,
        ARB_WAIT_BUSY = ST_WAIT_BUSY,
        ARB_WAIT_DONE = ST_WAIT_DONE
    } arb_state_e;

    // Cycles allowed between tx_load and the transmitter raising tx_busy.
    localparam int ARB_TIMEOUT = 16;
    localparam int ARB_TO_W    = 4;

    // Width of tx_src and of the round-robin pointer (up to 8 clients).
    localparam int SRC_W = 3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority select: the first asserted request found
// scanning upward from (ptr+1) mod NREQ, wrapping around.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [SRC_W-1:0] win_idx,
    output logic             any
);

    int cand;

    // Scan clients in priority order starting just after the last winner.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                win_idx      = SRC_W'(cand);
                win_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing the UART transmit path among NREQ byte
// clients. One issue per frame: grant + tx_load for one cycle, then wait for
// the transmitter to go busy and come back idle.
// Optional build macro: UART_ARB_TIMEOUT_EN adds a transmitter-start timeout
// that pulses err and returns to IDLE if tx_busy never rises.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// ARB_IDLE       | free; issues to the next requester when tx is idle
// ARB_WAIT_BUSY  | byte handed over, waiting for tx_busy to rise
// ARB_WAIT_DONE  | frame in flight, waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               baud_clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    grant,
    input  logic               tx_busy,
    output logic               tx_load,
    output logic [DW-1:0]      tx_data,
    output logic [SRC_W-1:0]   tx_src,
    output logic               arb_busy,
    output logic               err
);

    arb_state_e        state, state_nxt;
    logic [SRC_W-1:0]  ptr, ptr_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic              load_nxt;
    logic [DW-1:0]     data_nxt;
    logic [SRC_W-1:0]  src_nxt;

    logic [NREQ-1:0]   win_oh;
    logic [SRC_W-1:0]  win_idx;
    logic              win_any;
    logic [DW-1:0]     win_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [ARB_TO_W-1:0] TO_LAST = ARB_TO_W'(ARB_TIMEOUT - 1);
    logic [ARB_TO_W-1:0] to_cnt, to_cnt_nxt;
    logic                err_nxt;
`endif

    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Select the winning client's byte from the packed data bus.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) win_data = data_in[i*DW +: DW];
        end
    end

    // Next-state and next-output decode; outputs only change on an issue.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = '0;
        load_nxt  = 1'b0;
        data_nxt  = tx_data;
        src_nxt   = tx_src;
`ifdef UART_ARB_TIMEOUT_EN
        err_nxt    = 1'b0;
        to_cnt_nxt = to_cnt;
`endif
        case (state)
            ARB_IDLE: begin
                if (win_any && !tx_busy) begin
                    state_nxt = ARB_WAIT_BUSY;
                    grant_nxt = win_oh;
                    load_nxt  = 1'b1;
                    data_nxt  = win_data;
                    src_nxt   = win_idx;
                    ptr_nxt   = win_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end
            end
            ARB_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = ARB_WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Pointer keeps the failed winner, so it is not retried first.
                else if (to_cnt == TO_LAST) begin
                    state_nxt = ARB_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end
            ARB_WAIT_DONE: begin
                if (!tx_busy) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ARB_IDLE;
            ptr     <= SRC_W'(NREQ - 1);
            grant   <= '0;
            tx_load <= 1'b0;
            tx_data <= '0;
            tx_src  <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            grant   <= grant_nxt;
            tx_load <= load_nxt;
            tx_data <= data_nxt;
            tx_src  <= src_nxt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter-start timeout counter and its error pulse.
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            to_cnt <= to_cnt_nxt;
            err    <= err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign arb_busy = (state != ARB_IDLE);

endmodule
